// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the iterative integer divider.
// Imported by the interface, the restoring-step cell and the top.
package cpu_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } div_state_t;

    // Step-counter width for an arbitrary operand width (never below one bit).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/cpu_div_if.sv
// Request/response bundle between the CPU issue logic and the divide cell.
// The master issues the request; the slave is the divider.
interface cpu_div_if
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             D_div_start;
    logic             D_div_signed;
    logic [WIDTH-1:0] D_div_src1;
    logic [WIDTH-1:0] D_div_src2;
    logic             D_div_busy;
    logic             D_div_done;
    logic [WIDTH-1:0] D_div_quotient;
    logic [WIDTH-1:0] D_div_remainder;
    logic             D_div_by_zero;

    modport master (
        output D_div_start,
        output D_div_signed,
        output D_div_src1,
        output D_div_src2,
        input  D_div_busy,
        input  D_div_done,
        input  D_div_quotient,
        input  D_div_remainder,
        input  D_div_by_zero
    );

    modport slave (
        input  D_div_start,
        input  D_div_signed,
        input  D_div_src1,
        input  D_div_src2,
        output D_div_busy,
        output D_div_done,
        output D_div_quotient,
        output D_div_remainder,
        output D_div_by_zero
    );

endinterface

// File: rtl/cpu_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module cpu_div_step
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor on entry, so the trial result always fits WIDTH+1 signed bits.
    always_comb begin
        shifted  = {rem, bit_in};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/cpu_div_cell.sv
// Iterative restoring divider: sign-magnitude preparation, WIDTH single-bit
// steps, then sign fix-up; fixed latency of WIDTH+3 clock edges.
module cpu_div_cell
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    cpu_div_if.slave div
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] src1_reg;
    logic [WIDTH-1:0] src2_reg;
    logic             signed_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             zero_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] remo_reg;
    logic             by_zero_reg;

    logic [WIDTH-1:0] rem_step;
    logic             q_step;
    logic             neg1;
    logic             neg2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    cpu_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_reg),
        .divisor  (dsr_reg),
        .bit_in   (dvd_reg[WIDTH-1]),
        .rem_next (rem_step),
        .q_bit    (q_step)
    );

    // Magnitudes are plain WIDTH-bit unsigned, so -(2^(WIDTH-1)) maps to 2^(WIDTH-1).
    always_comb begin
        neg1     = signed_reg & src1_reg[WIDTH-1];
        neg2     = signed_reg & src2_reg[WIDTH-1];
        mag1     = neg1 ? -src1_reg : src1_reg;
        mag2     = neg2 ? -src2_reg : src2_reg;
        quot_fix = q_neg_reg ? -dvd_reg : dvd_reg;
        rem_fix  = r_neg_reg ? -rem_reg : rem_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            src1_reg    <= '0;
            src2_reg    <= '0;
            signed_reg  <= 1'b0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            rem_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            zero_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            quot_reg    <= '0;
            remo_reg    <= '0;
            by_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (div.D_div_start) begin
                        src1_reg   <= div.D_div_src1;
                        src2_reg   <= div.D_div_src2;
                        signed_reg <= div.D_div_signed;
                        busy_reg   <= 1'b1;
                        state_reg  <= PREP;
                    end
                end
                PREP: begin
                    dvd_reg   <= mag1;
                    dsr_reg   <= mag2;
                    q_neg_reg <= neg1 ^ neg2;
                    r_neg_reg <= neg1;
                    zero_reg  <= (src2_reg == '0);
                    rem_reg   <= '0;
                    cnt_reg   <= CW'(WIDTH - 1);
                    state_reg <= ITER;
                end
                ITER: begin
                    // Dividend bits leave at the top while quotient bits enter at the bottom.
                    rem_reg <= rem_step;
                    dvd_reg <= {dvd_reg[WIDTH-2:0], q_step};
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    quot_reg    <= zero_reg ? '1 : quot_fix;
                    remo_reg    <= zero_reg ? src1_reg : rem_fix;
                    by_zero_reg <= zero_reg;
                    done_reg    <= 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign div.D_div_busy      = busy_reg;
    assign div.D_div_done      = done_reg;
    assign div.D_div_quotient  = quot_reg;
    assign div.D_div_remainder = remo_reg;
    assign div.D_div_by_zero   = by_zero_reg;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Self-checking bench for cpu_div_cell: directed corner cases, protocol
// timing checks and randomized operands against an arithmetic reference.
module tb_cpu_div_cell;

    localparam int W       = 32;
    localparam int LATENCY = W + 3;

    logic clk;
    logic reset;

    int total;
    int bad;

    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_z;

    cpu_div_if #(.WIDTH(W)) bus ();

    cpu_div_cell #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .div   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: plain 64-bit arithmetic; '/' and '%' truncate toward zero.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa;
        longint sb;
        longint q64;
        longint r64;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            sa  = sgn ? longint'($signed(a)) : longint'(a);
            sb  = sgn ? longint'($signed(b)) : longint'(b);
            q64 = sa / sb;
            r64 = sa % sb;
            q   = q64[W-1:0];
            r   = r64[W-1:0];
            z   = 1'b0;
        end
    endtask

    // Called at a negedge; the request is sampled at the following posedge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        bus.D_div_start  = 1'b1;
        bus.D_div_src1   = a;
        bus.D_div_src2   = b;
        bus.D_div_signed = sgn;
        ref_div(a, b, sgn, exp_q, exp_r, exp_z);
        $display("start a=%h b=%h signed=%0d -> q=%h r=%h z=%0d", a, b, sgn, exp_q, exp_r, exp_z);
    endtask

    // Returns at the negedge inside the done cycle. inject_at>0 pulses a stray start then.
    task automatic wait_done(input string tag, input int inject_at);
        int cyc;
        bit seen;
        int busy_bad;
        cyc      = 0;
        seen     = 1'b0;
        busy_bad = 0;
        while (!seen && cyc < 3 * LATENCY) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            bus.D_div_start = 1'b0;
            if (cyc == inject_at) begin
                bus.D_div_start  = 1'b1;
                bus.D_div_src1   = $urandom;
                bus.D_div_src2   = $urandom_range(1, 9);
                bus.D_div_signed = $urandom_range(0, 1);
            end
            if (bus.D_div_done === 1'b1) seen = 1'b1;
            else if (bus.D_div_busy !== 1'b1) busy_bad++;
        end
        chk({tag, ".seen"}, W'(seen), W'(1));
        chk({tag, ".latency"}, W'(cyc), W'(LATENCY));
        chk({tag, ".busy_gaps"}, W'(busy_bad), W'(0));
        chk({tag, ".busy_at_done"}, W'(bus.D_div_busy), W'(0));
        chk({tag, ".quot"}, bus.D_div_quotient, exp_q);
        chk({tag, ".rem"}, bus.D_div_remainder, exp_r);
        chk({tag, ".by_zero"}, W'(bus.D_div_by_zero), W'(exp_z));
        $display("done %s cyc=%0d q=%h r=%h z=%0d", tag, cyc, bus.D_div_quotient,
                 bus.D_div_remainder, bus.D_div_by_zero);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.D_div_done === 1'b1) n++;
        end
    endtask

    initial begin
        int n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.D_div_start  = 1'b0;
        bus.D_div_signed = 1'b0;
        bus.D_div_src1   = '0;
        bus.D_div_src2   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst.busy", W'(bus.D_div_busy), W'(0));
        chk("rst.done", W'(bus.D_div_done), W'(0));
        chk("rst.quot", bus.D_div_quotient, W'(0));
        chk("rst.rem", bus.D_div_remainder, W'(0));
        chk("rst.by_zero", W'(bus.D_div_by_zero), W'(0));

        start_op(32'd100, 32'd7, 1'b0);            wait_done("u100_7", 0);
        @(negedge clk);
        start_op(32'hFFFF_FFF9, 32'd2, 1'b1);      wait_done("s_m7_2", 0);
        start_op(32'hFFFF_FFF9, 32'd2, 1'b0);      wait_done("u_m7_2", 0);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done("s_ovf", 0);
        start_op(32'd5, 32'd0, 1'b1);              wait_done("s_5_0", 0);
        start_op(32'd5, 32'd0, 1'b0);              wait_done("u_5_0", 0);

        // Stray start mid-operation, then a back-to-back start in the done cycle.
        @(negedge clk);
        start_op(32'd1000, 32'd33, 1'b0);          wait_done("ignore_start", 10);
        start_op(32'hFFFF_FC18, 32'd33, 1'b1);     wait_done("start_in_done", 0);
        count_dones(2 * LATENCY, n);
        chk("extra_dones", W'(n), W'(0));

        // Reset mid-flight discards the operation.
        start_op(32'd12345, 32'd11, 1'b0);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            bus.D_div_start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst.busy", W'(bus.D_div_busy), W'(0));
        chk("midrst.done", W'(bus.D_div_done), W'(0));
        chk("midrst.quot", bus.D_div_quotient, W'(0));
        chk("midrst.rem", bus.D_div_remainder, W'(0));
        chk("midrst.by_zero", W'(bus.D_div_by_zero), W'(0));
        count_dones(2 * LATENCY, n);
        chk("midrst.no_done", W'(n), W'(0));
        start_op(32'd12345, 32'd11, 1'b0);         wait_done("after_rst", 0);

        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : W'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'($urandom_range(1, 15));
                3:       b = W'($urandom) >> $urandom_range(1, 30);
                default: b = W'($urandom);
            endcase
            start_op(a, b, 1'($urandom_range(0, 1)));
            wait_done($sformatf("rand%0d", k), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
